// File: rtl/player_motion_if.sv
// Sprite RAM write bus carrying one descriptor word and its slot address.
interface player_motion_if;
   logic [31:0] dina;
   logic [2:0]  addr;

   modport master (output dina, output addr);
   modport slave  (input dina, input addr);
endinterface

// File: rtl/player_motion.sv
// Player controller: position, tick-based jump/fall physics, bounded horizontal
// movement, fall-out detection and animation, packed into one sprite descriptor.
module player_motion #(
   parameter int          TICK_DIV   = 100000,
   parameter int          GROUND_Y   = 400,
   parameter int          MIN_Y      = 32,
   parameter int          MAX_Y      = 480,
   parameter int          START_X    = 80,
   parameter int          MIN_X      = 0,
   parameter int          MAX_X      = 608,
   parameter int          X_STEP     = 2,
   parameter int          JUMP_V     = 12,
   parameter int          GRAVITY    = 1,
   parameter int          MAX_FALL_V = 8,
   parameter int          COOL_TICKS = 30,
   parameter int          RUN_FRAMES = 5,
   parameter int          ANIM_TICKS = 4,
   parameter logic [4:0]  SPRITE_ID  = 5'b10000,
   parameter int          SLOT       = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            up,
   input  logic            down,
   input  logic            left,
   input  logic            right,
   input  logic            game_over,
   input  logic            on_ground,
   output logic [9:0]      pos_x,
   output logic [9:0]      pos_y,
   output logic [1:0]      state,
   output logic            jumping,
   output logic            fell_out,
   player_motion_if.master spr
);

   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int COOL_W = $clog2(COOL_TICKS + 1);
   localparam int ANIM_W = $clog2(ANIM_TICKS + 1);

   localparam logic [9:0] GROUND_Y_P = 10'(GROUND_Y);
   localparam logic [9:0] MIN_Y_P    = 10'(MIN_Y);
   localparam logic [9:0] MAX_Y_P    = 10'(MAX_Y);
   localparam logic [9:0] START_X_P  = 10'(START_X);
   localparam logic [9:0] MIN_X_P    = 10'(MIN_X);
   localparam logic [9:0] MAX_X_P    = 10'(MAX_X);
   localparam logic [9:0] X_STEP_P   = 10'(X_STEP);

   localparam logic signed [7:0] JUMP_V_S   = 8'(JUMP_V);
   localparam logic signed [7:0] GRAVITY_S  = 8'(GRAVITY);
   localparam logic signed [7:0] MAX_FALL_S = 8'(MAX_FALL_V);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2,
      ST_DEAD   = 2'd3
   } state_t;

   // Clamped moves are evaluated 11 bits wide so x - X_STEP cannot wrap.
   function automatic logic [9:0] step_left(input logic [9:0] x);
      if ({1'b0, x} >= ({1'b0, MIN_X_P} + {1'b0, X_STEP_P})) begin
         step_left = x - X_STEP_P;
      end else begin
         step_left = MIN_X_P;
      end
   endfunction

   function automatic logic [9:0] step_right(input logic [9:0] x);
      if (({1'b0, x} + {1'b0, X_STEP_P}) >= {1'b0, MAX_X_P}) begin
         step_right = MAX_X_P;
      end else begin
         step_right = x + X_STEP_P;
      end
   endfunction

   function automatic logic [5:0] rom_row_col(input state_t st, input logic [2:0] fr);
      case (st)
         ST_GROUND: rom_row_col = {3'd0, fr};
         ST_RISE:   rom_row_col = {3'd1, 3'd0};
         ST_FALL:   rom_row_col = {3'd1, 3'd1};
         ST_DEAD:   rom_row_col = {3'd1, 3'd2};
         default:   rom_row_col = {3'd1, 3'd2};
      endcase
   endfunction

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              up_q, up_d, up_prev_q, up_prev_d;
   logic              jump_req_q, jump_req_d;
   logic [COOL_W-1:0] cool_q, cool_d;
   state_t            state_q, state_d;
   logic signed [7:0] vy_q, vy_d;
   logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [2:0]        frame_q, frame_d;
   logic [ANIM_W-1:0] anim_q, anim_d;
   logic              fell_out_q, fell_out_d;
   logic              jumping_q, jumping_d;
   logic [31:0]       dina_q, dina_d;

   logic              tick_s;
   logic              rise_clamp_s;
   logic [9:0]        rise_y_s;
   logic signed [7:0] vy_rise_s, vy_sum_s, vy_fall_s;
   logic [10:0]       cand_s;

   // Next-state computation for tick counter, jump request, physics, movement and descriptor.
   always_comb begin
      cnt_d      = cnt_q;
      up_d       = up;
      up_prev_d  = up_q;
      jump_req_d = jump_req_q;
      cool_d     = cool_q;
      state_d    = state_q;
      vy_d       = vy_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      frame_d    = frame_q;
      anim_d     = anim_q;
      fell_out_d = 1'b0;

      tick_s       = (cnt_q == CNT_W'(TICK_DIV - 1));
      rise_clamp_s = ({1'b0, pos_y_q} <= ({1'b0, MIN_Y_P} + {3'b000, vy_q}));
      rise_y_s     = rise_clamp_s ? MIN_Y_P : (pos_y_q - {2'b00, vy_q});
      vy_rise_s    = vy_q - GRAVITY_S;
      vy_sum_s     = vy_q + GRAVITY_S;
      vy_fall_s    = (vy_sum_s > MAX_FALL_S) ? MAX_FALL_S : vy_sum_s;
      cand_s       = {1'b0, pos_y_q} + {3'b000, vy_fall_s};

      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A request raised in the tick cycle itself survives to the next tick.
      if (game_over) begin
         jump_req_d = 1'b0;
      end else if (up_q && !up_prev_q) begin
         jump_req_d = 1'b1;
      end else if (tick_s) begin
         jump_req_d = 1'b0;
      end else begin
         jump_req_d = jump_req_q;
      end

      if (tick_s) begin
         if (cool_q != {COOL_W{1'b0}}) begin
            cool_d = cool_q - COOL_W'(1);
         end else begin
            cool_d = cool_q;
         end

         if (game_over) begin
            state_d = ST_DEAD;
         end else begin
            case (state_q)
               ST_GROUND: begin
                  if (jump_req_q && (cool_q == {COOL_W{1'b0}})) begin
                     state_d = ST_RISE;
                     vy_d    = JUMP_V_S;
                     cool_d  = COOL_W'(COOL_TICKS);
                  end else if (!on_ground) begin
                     state_d = ST_FALL;
                     vy_d    = 8'sd0;
                  end else if (anim_q == ANIM_W'(ANIM_TICKS - 1)) begin
                     anim_d  = {ANIM_W{1'b0}};
                     frame_d = (frame_q == 3'(RUN_FRAMES - 1)) ? 3'd0 : (frame_q + 3'd1);
                  end else begin
                     anim_d  = anim_q + ANIM_W'(1);
                  end
               end
               ST_RISE: begin
                  pos_y_d = rise_y_s;
                  if ((vy_rise_s <= 8'sd0) || rise_clamp_s || down) begin
                     state_d = ST_FALL;
                     vy_d    = 8'sd0;
                  end else begin
                     vy_d    = vy_rise_s;
                  end
               end
               ST_FALL: begin
                  vy_d = vy_fall_s;
                  if (on_ground && (pos_y_q <= GROUND_Y_P) && (cand_s >= {1'b0, GROUND_Y_P})) begin
                     pos_y_d = GROUND_Y_P;
                     state_d = ST_GROUND;
                     vy_d    = 8'sd0;
                     frame_d = 3'd0;
                     anim_d  = {ANIM_W{1'b0}};
                  end else if (cand_s >= {1'b0, MAX_Y_P}) begin
                     pos_y_d    = MAX_Y_P;
                     state_d    = ST_DEAD;
                     fell_out_d = 1'b1;
                  end else begin
                     pos_y_d = cand_s[9:0];
                  end
               end
               ST_DEAD: begin
                  state_d = ST_DEAD;
               end
               default: begin
                  state_d = ST_DEAD;
               end
            endcase

            if (state_q != ST_DEAD) begin
               if (left && !right) begin
                  pos_x_d = step_left(pos_x_q);
               end else if (right && !left) begin
                  pos_x_d = step_right(pos_x_q);
               end else begin
                  pos_x_d = pos_x_q;
               end
            end else begin
               pos_x_d = pos_x_q;
            end
         end
      end else begin
         cool_d = cool_q;
      end

      jumping_d = (state_d == ST_RISE) || (state_d == ST_FALL);
      dina_d    = {SPRITE_ID, 1'b0, pos_x_d, pos_y_d, rom_row_col(state_d, frame_d)};
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= {CNT_W{1'b0}};
         up_q       <= 1'b0;
         up_prev_q  <= 1'b0;
         jump_req_q <= 1'b0;
         cool_q     <= {COOL_W{1'b0}};
         state_q    <= ST_GROUND;
         vy_q       <= 8'sd0;
         pos_x_q    <= START_X_P;
         pos_y_q    <= GROUND_Y_P;
         frame_q    <= 3'd0;
         anim_q     <= {ANIM_W{1'b0}};
         fell_out_q <= 1'b0;
         jumping_q  <= 1'b0;
         dina_q     <= {SPRITE_ID, 1'b0, START_X_P, GROUND_Y_P, 6'd0};
      end else begin
         cnt_q      <= cnt_d;
         up_q       <= up_d;
         up_prev_q  <= up_prev_d;
         jump_req_q <= jump_req_d;
         cool_q     <= cool_d;
         state_q    <= state_d;
         vy_q       <= vy_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         frame_q    <= frame_d;
         anim_q     <= anim_d;
         fell_out_q <= fell_out_d;
         jumping_q  <= jumping_d;
         dina_q     <= dina_d;
      end
   end

   assign pos_x    = pos_x_q;
   assign pos_y    = pos_y_q;
   assign state    = state_q;
   assign jumping  = jumping_q;
   assign fell_out = fell_out_q;
   assign spr.dina = dina_q;
   assign spr.addr = 3'(SLOT);

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_player_motion;
   localparam int TICK_DIV = 4;
   localparam int F_X = 0, F_Y = 1, F_ST = 2, F_JMP = 3, F_FO = 4, F_DINA = 5, F_ADDR = 6, F_COL = 7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic       game_over = 1'b0, on_ground = 1'b1;
   logic [9:0] pos_x, pos_y;
   logic [1:0] state;
   logic       jumping, fell_out;

   player_motion_if spr_if ();

   player_motion #(.TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
      .game_over(game_over), .on_ground(on_ground), .pos_x(pos_x), .pos_y(pos_y),
      .state(state), .jumping(jumping), .fell_out(fell_out), .spr(spr_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          field;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   int rise_tab[12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};
   int fall_tab[14] = '{323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400};
   int cliff_tab[13] = '{401, 403, 406, 410, 415, 421, 428, 436, 444, 452, 460, 468, 476};
   int col_tab[5] = '{1, 2, 3, 4, 0};

   function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y,
                                        input logic [2:0] r, input logic [2:0] c);
      return {5'b10000, 1'b0, x, y, r, c};
   endfunction

   function automatic logic [31:0] actual(input int f);
      case (f)
         F_X:     return 32'(pos_x);
         F_Y:     return 32'(pos_y);
         F_ST:    return 32'(state);
         F_JMP:   return 32'(jumping);
         F_FO:    return 32'(fell_out);
         F_DINA:  return spr_if.dina;
         F_ADDR:  return 32'(spr_if.addr);
         F_COL:   return 32'(spr_if.dina[2:0]);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic expect_val(input string name, input int field, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.field = field;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_tick();
      do step(); while (cyc % TICK_DIV != 0);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   // Called right after a tick: the registered edge reaches jump_req before the next tick.
   task automatic pulse_up();
      up = 1'b1;
      step();
      step();
      up = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic expect_reset_values(input string tag);
      expect_val({tag, "_x"}, F_X, 32'd80);
      expect_val({tag, "_y"}, F_Y, 32'd400);
      expect_val({tag, "_state"}, F_ST, 32'd0);
      expect_val({tag, "_jumping"}, F_JMP, 32'd0);
      expect_val({tag, "_fell_out"}, F_FO, 32'd0);
      expect_val({tag, "_dina"}, F_DINA, pack(10'd80, 10'd400, 3'd0, 3'd0));
      expect_val({tag, "_addr"}, F_ADDR, 32'd0);
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         logic [31:0] a;
         e = sb_q.pop_front();
         a = actual(e.field);
         checks++;
         if (a !== e.exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t",
                     e.name, a, a, e.exp, e.exp, $time);
         end
      end
   end

   initial begin
      apply_reset();
      expect_reset_values("reset");

      // Both directions held: x holds while the run animation cycles.
      left = 1'b1;
      right = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         do_tick();
         if (t % 4 == 0) expect_val("anim_col", F_COL, 32'(col_tab[t / 4 - 1]));
      end
      expect_val("both_hold_x", F_X, 32'd80);
      expect_val("ground_dina", F_DINA, pack(10'd80, 10'd400, 3'd0, 3'd0));
      left = 1'b0;
      right = 1'b0;

      // Full jump.
      pulse_up();
      do_tick();
      expect_val("jump_start_state", F_ST, 32'd1);
      expect_val("jump_start_jumping", F_JMP, 32'd1);
      expect_val("jump_start_y", F_Y, 32'd400);
      for (int i = 0; i < 12; i++) begin
         do_tick();
         expect_val("rise_y", F_Y, 32'(rise_tab[i]));
         if (i == 10) expect_val("rise_state", F_ST, 32'd1);
      end
      expect_val("apex_state", F_ST, 32'd2);
      expect_val("apex_dina", F_DINA, pack(10'd80, 10'd322, 3'd1, 3'd1));
      for (int i = 0; i < 14; i++) begin
         do_tick();
         expect_val("fall_y", F_Y, 32'(fall_tab[i]));
         if (i == 12) expect_val("fall_jumping", F_JMP, 32'd1);
      end
      expect_val("land_state", F_ST, 32'd0);
      expect_val("land_jumping", F_JMP, 32'd0);

      // Cool-down: request just after landing is discarded, later one is taken.
      pulse_up();
      do_tick();
      expect_val("cool_reject_state", F_ST, 32'd0);
      do_ticks(3);
      expect_val("cool_pending_state", F_ST, 32'd0);
      pulse_up();
      do_tick();
      expect_val("cool_accept_state", F_ST, 32'd1);

      // Fast drop on the third rise tick.
      do_ticks(2);
      expect_val("pre_drop_y", F_Y, 32'd377);
      down = 1'b1;
      do_tick();
      down = 1'b0;
      expect_val("drop_y", F_Y, 32'd367);
      expect_val("drop_state", F_ST, 32'd2);
      do_tick();
      expect_val("drop_next_y", F_Y, 32'd368);
      do_ticks(7);
      expect_val("drop_land_y", F_Y, 32'd400);
      expect_val("drop_land_state", F_ST, 32'd0);

      // Left bound.
      left = 1'b1;
      do_tick();
      expect_val("left_first_x", F_X, 32'd78);
      do_ticks(38);
      expect_val("left_near_x", F_X, 32'd2);
      do_tick();
      expect_val("left_min_x", F_X, 32'd0);
      do_ticks(2);
      expect_val("left_hold_x", F_X, 32'd0);
      left = 1'b0;

      // Right bound.
      right = 1'b1;
      do_ticks(303);
      expect_val("right_near_x", F_X, 32'd606);
      do_tick();
      expect_val("right_max_x", F_X, 32'd608);
      do_ticks(2);
      expect_val("right_hold_x", F_X, 32'd608);
      right = 1'b0;

      // Pending jump and game_over in the same tick: DEAD wins.
      pulse_up();
      step();
      game_over = 1'b1;
      step();
      game_over = 1'b0;
      expect_val("prio_state", F_ST, 32'd3);
      expect_val("prio_jumping", F_JMP, 32'd0);
      expect_val("prio_dina", F_DINA, pack(10'd608, 10'd400, 3'd1, 3'd2));
      up = 1'b1;
      left = 1'b1;
      do_ticks(3);
      up = 1'b0;
      left = 1'b0;
      expect_val("dead_state", F_ST, 32'd3);
      expect_val("dead_x", F_X, 32'd608);
      expect_val("dead_y", F_Y, 32'd400);

      // Cliff fall-out.
      apply_reset();
      on_ground = 1'b0;
      do_tick();
      expect_val("cliff_state", F_ST, 32'd2);
      expect_val("cliff_y0", F_Y, 32'd400);
      expect_val("cliff_jumping", F_JMP, 32'd1);
      for (int i = 0; i < 13; i++) begin
         do_tick();
         expect_val("cliff_y", F_Y, 32'(cliff_tab[i]));
      end
      expect_val("cliff_pre_state", F_ST, 32'd2);
      do_tick();
      expect_val("fallout_y", F_Y, 32'd480);
      expect_val("fallout_state", F_ST, 32'd3);
      expect_val("fallout_pulse", F_FO, 32'd1);
      step();
      expect_val("fallout_pulse_end", F_FO, 32'd0);
      expect_val("fallout_dead", F_ST, 32'd3);
      on_ground = 1'b1;
      right = 1'b1;
      up = 1'b1;
      do_ticks(3);
      up = 1'b0;
      right = 1'b0;
      expect_val("fallout_frozen_x", F_X, 32'd80);
      expect_val("fallout_frozen_y", F_Y, 32'd480);
      expect_val("fallout_frozen_fo", F_FO, 32'd0);

      // Reset in the middle of a rise.
      apply_reset();
      pulse_up();
      do_ticks(3);
      expect_val("midrise_state", F_ST, 32'd1);
      expect_val("midrise_y", F_Y, 32'd377);
      reset = 1'b1;
      step();
      expect_reset_values("midrise_reset");
      step();
      reset = 1'b0;
      cyc = 0;

      repeat (3) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
